// File: rtl/acl2_spi_master.sv
// SPI mode-0 master framing ADXL362 register/FIFO accesses.
// Optional INT1 auto-read of XDATA..ZDATA: define ACL2_SPI_INT_AUTOREAD_EN.
module acl2_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rw,
  input  logic             fifo_rd,
  input  logic [7:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  output logic             tx_next,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             SCLK,
  output logic             MOSI,
  output logic             nCS,
  input  logic             MISO,
  input  logic             INT1
);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP
  } state_t;

  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);
  localparam logic [CW-1:0] GAP  = CW'(2 * CLK_DIV - 1);
  localparam logic [LEN_W:0] ONE = 1;
  localparam logic [LEN_W:0] TWO = 2;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_cnt;
  logic [LEN_W:0]   byte_idx;
  logic [LEN_W:0]   total;
  logic             rd_q;
  logic             fifo_q;
  logic [7:0]       addr_q;
  logic [7:0]       sh;
  logic [7:0]       rx_sh;
  logic             rx_pend;
  logic             sclk_q;
  logic             ncs_q;
  logic             busy_q;
  logic             done_q;
  logic             tx_next_q;
  logic             rx_valid_q;
  logic [7:0]       rx_data_q;

  logic             go;
  logic             g_rw;
  logic             g_fifo;
  logic [7:0]       g_addr;
  logic [LEN_W-1:0] g_len;

`ifdef ACL2_SPI_INT_AUTOREAD_EN
  logic [2:0] int_sync;
  logic       int_pend;
  logic       int_edge;
  logic       auto_go;

  assign int_edge = int_sync[1] & ~int_sync[2];
  assign auto_go  = (state == IDLE) && !start &&
                    (int_edge || int_pend);

  // A user start wins; the edge is parked in int_pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_sync <= '0;
      int_pend <= 1'b0;
    end else begin
      int_sync <= {int_sync[1:0], INT1};
      if (auto_go)
        int_pend <= 1'b0;
      else if (int_edge)
        int_pend <= 1'b1;
    end
  end

  always_comb begin
    go     = start | auto_go;
    g_rw   = auto_go ? 1'b1 : rw;
    g_fifo = auto_go ? 1'b0 : fifo_rd;
    g_addr = auto_go ? 8'h0E : addr;
    g_len  = auto_go ? LEN_W'(6) : len;
  end
`else
  logic unused_int1;
  assign unused_int1 = INT1;

  always_comb begin
    go     = start;
    g_rw   = rw;
    g_fifo = fifo_rd;
    g_addr = addr;
    g_len  = len;
  end
`endif

  logic [7:0]     g_cmd;
  logic [LEN_W:0] g_hdr;
  logic [LEN_W:0] hdr;
  logic [LEN_W:0] nxt_idx;
  logic [7:0]     nxt_byte;
  logic           nxt_wr;

  always_comb begin
    g_cmd    = g_fifo ? 8'h0D : (g_rw ? 8'h0B : 8'h0A);
    g_hdr    = g_fifo ? ONE : TWO;
    hdr      = fifo_q ? ONE : TWO;
    nxt_idx  = byte_idx + 1'b1;
    nxt_wr   = !rd_q && (nxt_idx >= hdr) && (nxt_idx < total);
    nxt_byte = 8'h00;
    if (nxt_idx == ONE && !fifo_q)
      nxt_byte = addr_q;
    else if (!rd_q)
      nxt_byte = tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      total      <= '0;
      rd_q       <= 1'b0;
      fifo_q     <= 1'b0;
      addr_q     <= '0;
      sh         <= '0;
      rx_sh      <= '0;
      rx_pend    <= 1'b0;
      sclk_q     <= 1'b0;
      ncs_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_next_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      tx_next_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_pend    <= 1'b0;
      if (rx_pend) begin
        rx_data_q  <= rx_sh;
        rx_valid_q <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (go) begin
            rd_q     <= g_fifo | g_rw;
            fifo_q   <= g_fifo;
            addr_q   <= g_addr;
            total    <= {1'b0, g_len} + g_hdr;
            sh       <= g_cmd;
            ncs_q    <= 1'b0;
            busy_q   <= 1'b1;
            cnt      <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            state    <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // Announce the capture one cycle ahead so tx_next
          // is high in the very cycle tx_data is sampled.
          if (cnt == PRE && sclk_q && bit_cnt == 3'd7 && nxt_wr)
            tx_next_q <= 1'b1;
          if (cnt != HALF) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt    <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rx_sh <= {rx_sh[6:0], MISO};
              if (bit_cnt == 3'd7 && rd_q && byte_idx >= hdr)
                rx_pend <= 1'b1;
            end else if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 1'b1;
              sh      <= {sh[6:0], 1'b0};
            end else begin
              bit_cnt  <= '0;
              byte_idx <= nxt_idx;
              if (nxt_idx == total) begin
                sh    <= '0;
                state <= CS_HOLD;
              end else begin
                sh <= nxt_byte;
              end
            end
          end
        end
        CS_HOLD: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            ncs_q <= 1'b1;
            state <= CS_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CS_GAP: begin
          if (cnt == GAP) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SCLK     = sclk_q;
  assign MOSI     = sh[7];
  assign nCS      = ncs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_next  = tx_next_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_acl2_spi_master.sv
// Randomized bench for acl2_spi_master with an ADXL362-style
// slave model and byte-level expected-frame reference.
module tb_acl2_spi_master;

  localparam int CLK_DIV = 4;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             rw = 1'b0;
  logic             fifo_rd = 1'b0;
  logic [7:0]       addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0]       tx_data = '0;
  logic             MISO = 1'b0;
  logic             INT1 = 1'b0;
  logic             tx_next;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;
  logic             SCLK;
  logic             MOSI;
  logic             nCS;

  acl2_spi_master #(
    .CLK_DIV(CLK_DIV),
    .LEN_W  (LEN_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .fifo_rd (fifo_rd),
    .addr    (addr),
    .len     (len),
    .tx_data (tx_data),
    .tx_next (tx_next),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .done    (done),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .nCS     (nCS),
    .MISO    (MISO),
    .INT1    (INT1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  logic [7:0] mosi_cap[$];
  logic [7:0] rx_got[$];
  logic [7:0] s_tx[$];
  logic [7:0] tx_q[$];
  int         rx_cyc[$];
  int n_rise, n_txnext, n_done, n_frames, n_ncs_rise;
  int ncs_bad, per_bad, s_bit, last_rise, cyc;
  int exp_rises, exp_txn;
  logic [7:0] s_acc;

  function automatic logic slave_bit(input int n);
    logic [7:0] b;
    b = (n / 8 < s_tx.size()) ? s_tx[n / 8] : 8'h00;
    return b[7 - (n % 8)];
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_next) n_txnext++;
    if (done) n_done++;
    if (rx_valid) begin
      rx_got.push_back(rx_data);
      rx_cyc.push_back(cyc);
    end
  end

  // Slave: sample MOSI on rise, present next MISO bit on fall.
  always @(negedge nCS) begin
    s_bit = 0;
    n_frames++;
    MISO = slave_bit(0);
  end

  always @(posedge nCS) n_ncs_rise++;

  always @(posedge SCLK) begin
    if (nCS) ncs_bad++;
    if (s_bit > 0 && cyc - last_rise != 2 * CLK_DIV) per_bad++;
    last_rise = cyc;
    s_acc = {s_acc[6:0], MOSI};
    s_bit++;
    n_rise++;
    if (s_bit % 8 == 0) mosi_cap.push_back(s_acc);
  end

  always @(negedge SCLK) if (!nCS) MISO = slave_bit(s_bit);

  // Host side: present the next write byte after each capture.
  always @(posedge clk) begin
    if (tx_next) begin
      #1;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
      tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'($urandom);
    end
  end

  task automatic clear_all();
    n_rise = 0; n_txnext = 0; n_done = 0; n_frames = 0;
    n_ncs_rise = 0; ncs_bad = 0; per_bad = 0;
    exp_rises = 0; exp_txn = 0;
    exp_mosi.delete(); exp_rx.delete(); mosi_cap.delete();
    rx_got.delete(); rx_cyc.delete(); s_tx.delete(); tx_q.delete();
  endtask

  task automatic add_frame(input logic r, input logic f,
                           input logic [7:0] a, input int l);
    int hdr;
    logic [7:0] d, w;
    hdr = f ? 1 : 2;
    s_tx.delete();
    for (int i = 0; i < hdr; i++) s_tx.push_back(8'($urandom));
    exp_mosi.push_back(f ? 8'h0D : (r ? 8'h0B : 8'h0A));
    if (!f) exp_mosi.push_back(a);
    for (int i = 0; i < l; i++) begin
      d = 8'($urandom);
      w = 8'($urandom);
      s_tx.push_back(d);
      if (f || r) begin
        exp_mosi.push_back(8'h00);
        exp_rx.push_back(d);
      end else begin
        exp_mosi.push_back(w);
        tx_q.push_back(w);
        exp_txn++;
      end
    end
    exp_rises += 8 * (hdr + l);
    tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 1);
  endtask

  task automatic check_frames(input int nfr);
    int g;
    repeat (4 * CLK_DIV) @(negedge clk);
    chk("done_cnt", n_done, nfr);
    chk("frames", n_frames, nfr);
    chk("ncs_rise", n_ncs_rise, nfr);
    chk("sclk_rises", n_rise, exp_rises);
    chk("ncs_low_at_rise", ncs_bad, 0);
    chk("sclk_period", per_bad, 0);
    chk("tx_next_cnt", n_txnext, exp_txn);
    chk("mosi_cnt", mosi_cap.size(), exp_mosi.size());
    for (int i = 0; i < exp_mosi.size(); i++) begin
      g = (i < mosi_cap.size()) ? int'(mosi_cap[i]) : -1;
      chk("mosi_byte", g, 32'(exp_mosi[i]));
    end
    chk("rx_cnt", rx_got.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size(); i++) begin
      g = (i < rx_got.size()) ? int'(rx_got[i]) : -1;
      chk("rx_data", g, 32'(exp_rx[i]));
    end
    if (nfr == 1)
      for (int i = 1; i < rx_cyc.size(); i++)
        chk("rx_spacing", rx_cyc[i] - rx_cyc[i-1], 16 * CLK_DIV);
    chk("busy_idle", 32'(busy), 0);
    chk("ncs_idle", 32'(nCS), 1);
  endtask

  task automatic launch(input logic r, input logic f,
                        input logic [7:0] a, input int l);
    @(negedge clk);
    start = 1'b1; rw = r; fifo_rd = f; addr = a; len = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
    rw = 1'($urandom); fifo_rd = 1'($urandom);
    addr = 8'($urandom); len = LEN_W'($urandom);
    chk("busy_set", 32'(busy), 1);
  endtask

  task automatic run_frame(input logic r, input logic f,
                           input logic [7:0] a, input int l,
                           input bit poke);
    clear_all();
    add_frame(r, f, a, l);
    launch(r, f, a, l);
    if (poke) begin
      repeat (30) @(negedge clk);
      start = 1'b1; rw = ~r; fifo_rd = ~f; addr = ~a; len = '1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(16 * CLK_DIV * (3 + l));
    check_frames(1);
  endtask

  initial begin
    clear_all();
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(SCLK), 0);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_ncs", 32'(nCS), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx_next", 32'(tx_next), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1'b0, 1'b0, 8'h2D, 1, 1'b0);
    run_frame(1'b1, 1'b0, 8'h00, 1, 1'b0);
    run_frame(1'b1, 1'b0, 8'h0E, 6, 1'b0);
    run_frame(1'b0, 1'b1, 8'h00, 2, 1'b0);
    run_frame(1'b0, 1'b0, 8'h20, 3, 1'b1);
    run_frame(1'b1, 1'b0, 8'h05, 0, 1'b0);
    run_frame(1'b0, 1'b1, 8'h00, 0, 1'b0);
    repeat (12)
      run_frame(1'($urandom), 1'($urandom), 8'($urandom),
                $urandom_range(0, 5), 1'b0);

    // Abort mid-shift with reset, then a clean frame.
    clear_all();
    add_frame(1'b0, 1'b0, 8'h1F, 3);
    launch(1'b0, 1'b0, 8'h1F, 3);
    repeat (60) @(negedge clk);
    chk("busy_mid", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ncs", 32'(nCS), 1);
    chk("abort_sclk", 32'(SCLK), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort_no_done", n_done, 0);
    run_frame(1'b1, 1'b0, 8'h08, 2, 1'b0);

`ifdef ACL2_SPI_INT_AUTOREAD_EN
    begin
      int m;
      clear_all();
      add_frame(1'b1, 1'b0, 8'h0E, 6);
      m = exp_mosi.size();
      for (int i = 0; i < m; i++) exp_mosi.push_back(exp_mosi[i]);
      m = exp_rx.size();
      for (int i = 0; i < m; i++) exp_rx.push_back(exp_rx[i]);
      exp_rises = 2 * exp_rises;
      @(negedge clk) INT1 = 1'b1;
      repeat (100) @(negedge clk);
      INT1 = 1'b0;
      repeat (5) @(negedge clk);
      INT1 = 1'b1;
      wait_done(16 * CLK_DIV * 10);
      wait_done(16 * CLK_DIV * 10);
      INT1 = 1'b0;
      check_frames(2);
    end
`else
    clear_all();
    @(negedge clk) INT1 = 1'b1;
    repeat (200) @(negedge clk);
    chk("int1_ignored", n_frames, 0);
    INT1 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
